reg_read_port: RTL and testbench



---
 rtl/reg_read_port_pkg.sv | 20 ++
 rtl/reg_read_port_snap_fifo.sv | 59 +++++
 rtl/reg_read_port.sv | 93 +++++++++
 tb/tb_reg_read_port.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/reg_read_port_pkg.sv
// Shared types and constants for the register read-back port.
// Holds the FSM state enum, the default widths, the beat count and the drop counter width.
package reg_read_port_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_BYTE_W = 8;
  localparam int BEATS      = DEF_DATA_W / DEF_BYTE_W;
  localparam int DROP_W     = 8;

  // Index width that stays at least one bit for single-entry ranges.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reg_read_port_snap_fifo.sv
// Circular snapshot buffer, DEPTH x DATA_W, with occupancy counter.
// Ports: push/wdata in, pop in, rdata = head word, full/empty/count out.
module snap_fifo
  import reg_read_port_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = 2,
  parameter int CW     = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty,
  output logic [CW-1:0]     count
);

  localparam int PW = idx_w(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]     wr_q, wr_d;
  logic [PW-1:0]     rd_q, rd_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q + CW'(push) - CW'(pop);
    if (push) wr_d = (wr_q == LAST) ? '0 : wr_q + 1'b1;
    if (pop)  rd_d = (rd_q == LAST) ? '0 : rd_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage is never exposed while empty, so it needs no reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= wdata;
  end

  assign rdata = mem_q[rd_q];
  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);
  assign count = cnt_q;

endmodule

// File: rtl/reg_read_port.sv
// Snapshots reg_data on request and streams each word out LSB byte first.
// Ports: rd_req/rd_ready request side, out_* beat stream, drop_cnt of refusals.
module reg_read_port
  import reg_read_port_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int BYTE_W = DEF_BYTE_W,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] reg_data,
  input  logic              rd_req,
  output logic              rd_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BYTE_W-1:0] out_data,
  output logic              out_last,
  output logic [DROP_W-1:0] drop_cnt
);

  localparam int NB = DATA_W / BYTE_W;
  localparam int BW = idx_w(NB);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(NB - 1);

  state_t            state_q, state_d;
  logic [BW-1:0]     beat_q, beat_d;
  logic [DROP_W-1:0] drop_q, drop_d;

  logic              push, pop, full, empty;
  logic              beat_done;
  logic [CW-1:0]     count, cnt_nxt;
  logic [DATA_W-1:0] head;

  snap_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .CW     (CW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (reg_data),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // Full is judged on the registered occupancy, so a pop cannot free a slot
  // for a request on the same edge.
  assign push      = rd_req && !full;
  assign beat_done = (state_q == SEND) && out_ready;
  assign pop       = beat_done && (beat_q == LAST_BEAT);
  assign cnt_nxt   = count + CW'(push) - CW'(pop);

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    drop_d  = drop_q;
    unique case (state_q)
      IDLE: if (cnt_nxt != '0) state_d = SEND;
      SEND: if (pop && cnt_nxt == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (beat_done) beat_d = pop ? '0 : beat_q + 1'b1;
    if (rd_req && full && drop_q != '1) drop_d = drop_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      drop_q  <= drop_d;
    end
  end

  assign out_valid = (state_q == SEND);
  assign out_data  = out_valid ? head[beat_q*BYTE_W +: BYTE_W] : '0;
  assign out_last  = out_valid && (beat_q == LAST_BEAT);
  assign rd_ready  = !full;
  assign drop_cnt  = drop_q;

  logic unused_empty;
  assign unused_empty = empty;

endmodule

// File: tb/tb_reg_read_port.sv
// Directed bench for reg_read_port: vector table plus corner sequences.
// Inputs change 1ns after the rising edge; outputs are checked there too.
module tb_reg_read_port;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] reg_data;
  logic        rd_req;
  logic        rd_ready;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_last;
  logic [7:0]  drop_cnt;

  int checks = 0;
  int errors = 0;

  reg_read_port dut (
    .clk       (clk),
    .rst       (rst),
    .reg_data  (reg_data),
    .rd_req    (rd_req),
    .rd_ready  (rd_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        req;
    logic        ordy;
    logic [15:0] d;
    logic        v;
    logic [7:0]  od;
    logic        l;
    logic        rdy;
    logic [7:0]  dc;
  } vec_t;

  vec_t tbl [25];

  task automatic chk(input string name, input logic [15:0] got,
                     input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [7:0] od,
                         input logic l, input logic rdy, input logic [7:0] dc);
    chk({tag, " out_valid"}, {15'd0, out_valid}, {15'd0, v});
    chk({tag, " out_data"},  {8'd0, out_data},   {8'd0, od});
    chk({tag, " out_last"},  {15'd0, out_last},  {15'd0, l});
    chk({tag, " rd_ready"},  {15'd0, rd_ready},  {15'd0, rdy});
    chk({tag, " drop_cnt"},  {8'd0, drop_cnt},   {8'd0, dc});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic req, input logic ordy,
                              input logic [15:0] d, input logic v,
                              input logic [7:0] od, input logic l,
                              input logic rdy, input logic [7:0] dc);
    vec_t r;
    r.req = req; r.ordy = ordy; r.d = d;
    r.v = v; r.od = od; r.l = l; r.rdy = rdy; r.dc = dc;
    return r;
  endfunction

  initial begin
    // single read
    tbl[0]  = mk(1'b1, 1'b1, 16'h00fe, 1'b1, 8'hfe, 1'b0, 1'b1, 8'd0);
    tbl[1]  = mk(1'b0, 1'b1, 16'h0000, 1'b1, 8'h00, 1'b1, 1'b1, 8'd0);
    tbl[2]  = mk(1'b0, 1'b1, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b1, 8'd0);
    // back-pressure
    tbl[3]  = mk(1'b1, 1'b0, 16'h0fe6, 1'b1, 8'he6, 1'b0, 1'b1, 8'd0);
    tbl[4]  = mk(1'b0, 1'b0, 16'h0000, 1'b1, 8'he6, 1'b0, 1'b1, 8'd0);
    tbl[5]  = mk(1'b0, 1'b0, 16'h0000, 1'b1, 8'he6, 1'b0, 1'b1, 8'd0);
    tbl[6]  = mk(1'b0, 1'b0, 16'h0000, 1'b1, 8'he6, 1'b0, 1'b1, 8'd0);
    tbl[7]  = mk(1'b0, 1'b1, 16'h0000, 1'b1, 8'h0f, 1'b1, 1'b1, 8'd0);
    tbl[8]  = mk(1'b0, 1'b1, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b1, 8'd0);
    // full and drop
    tbl[9]  = mk(1'b1, 1'b0, 16'h00fe, 1'b1, 8'hfe, 1'b0, 1'b1, 8'd0);
    tbl[10] = mk(1'b1, 1'b0, 16'h0fe6, 1'b1, 8'hfe, 1'b0, 1'b0, 8'd0);
    tbl[11] = mk(1'b1, 1'b0, 16'h1234, 1'b1, 8'hfe, 1'b0, 1'b0, 8'd1);
    tbl[12] = mk(1'b0, 1'b1, 16'h0000, 1'b1, 8'h00, 1'b1, 1'b0, 8'd1);
    tbl[13] = mk(1'b0, 1'b1, 16'h0000, 1'b1, 8'he6, 1'b0, 1'b1, 8'd1);
    tbl[14] = mk(1'b0, 1'b1, 16'h0000, 1'b1, 8'h0f, 1'b1, 1'b1, 8'd1);
    tbl[15] = mk(1'b0, 1'b1, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b1, 8'd1);
    // pop on the same edge as a request while full: no bypass
    tbl[16] = mk(1'b1, 1'b0, 16'h1111, 1'b1, 8'h11, 1'b0, 1'b1, 8'd1);
    tbl[17] = mk(1'b1, 1'b0, 16'h2222, 1'b1, 8'h11, 1'b0, 1'b0, 8'd1);
    tbl[18] = mk(1'b0, 1'b1, 16'h0000, 1'b1, 8'h11, 1'b1, 1'b0, 8'd1);
    tbl[19] = mk(1'b1, 1'b1, 16'h3333, 1'b1, 8'h22, 1'b0, 1'b1, 8'd2);
    tbl[20] = mk(1'b1, 1'b0, 16'h3333, 1'b1, 8'h22, 1'b0, 1'b0, 8'd2);
    tbl[21] = mk(1'b0, 1'b1, 16'h0000, 1'b1, 8'h22, 1'b1, 1'b0, 8'd2);
    tbl[22] = mk(1'b0, 1'b1, 16'h0000, 1'b1, 8'h33, 1'b0, 1'b1, 8'd2);
    tbl[23] = mk(1'b0, 1'b1, 16'h0000, 1'b1, 8'h33, 1'b1, 1'b1, 8'd2);
    tbl[24] = mk(1'b0, 1'b1, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b1, 8'd2);

    rst = 1'b1;
    rd_req = 1'b0;
    out_ready = 1'b0;
    reg_data = 16'h0;
    tick();
    tick();
    chk_out("reset", 1'b0, 8'h00, 1'b0, 1'b1, 8'd0);
    rst = 1'b0;
    tick();

    foreach (tbl[i]) begin
      rd_req    = tbl[i].req;
      out_ready = tbl[i].ordy;
      reg_data  = tbl[i].d;
      tick();
      chk_out($sformatf("vec%0d", i), tbl[i].v, tbl[i].od, tbl[i].l,
              tbl[i].rdy, tbl[i].dc);
    end

    // asynchronous reset in the middle of a word
    rd_req = 1'b1;
    out_ready = 1'b1;
    reg_data = 16'h00fe;
    tick();
    rd_req = 1'b0;
    chk_out("pre_rst", 1'b1, 8'hfe, 1'b0, 1'b1, 8'd2);
    #2 rst = 1'b1;
    #1;
    chk_out("mid_rst", 1'b0, 8'h00, 1'b0, 1'b1, 8'd0);
    #1 rst = 1'b0;
    rd_req = 1'b1;
    reg_data = 16'h1234;
    tick();
    rd_req = 1'b0;
    chk_out("post_rst0", 1'b1, 8'h34, 1'b0, 1'b1, 8'd0);
    tick();
    chk_out("post_rst1", 1'b1, 8'h12, 1'b1, 1'b1, 8'd0);
    tick();
    chk_out("post_rst2", 1'b0, 8'h00, 1'b0, 1'b1, 8'd0);

    // drop counter saturation: 2 accepts then 260 refusals
    out_ready = 1'b0;
    rd_req = 1'b1;
    reg_data = 16'habcd;
    for (int i = 0; i < 262; i++) begin
      tick();
      if (i == 255) chk("drop_fe", {8'd0, drop_cnt}, 16'h00fe);
    end
    rd_req = 1'b0;
    chk_out("saturate", 1'b1, 8'hcd, 1'b0, 1'b0, 8'hff);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
